// File: rtl/gt_serial_pkg.sv
// rtl/gt_serial_pkg.sv - shared types and constants for the serial magnitude comparator
package gt_serial_pkg;

  // Number of operand bits consumed per clock by the compare slice
  localparam int SLICE_W = 2;

  // Controller states; 2-bit encoding kept stable for downstream debug taps
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cmp2_slice.sv
// rtl/cmp2_slice.sv - combinational 2-bit unsigned magnitude compare slice
module cmp2_slice (
  input  logic [1:0] x,
  input  logic [1:0] y,
  output logic       gt,
  output logic       eq
);

  // Single shared comparator; the controller walks operands through it MSB-first
  always_comb begin
    gt = (x > y);
    eq = (x == y);
  end

endmodule

// File: rtl/gt_serial_ctrl.sv
// rtl/gt_serial_ctrl.sv - sequential MSB-first magnitude comparator with start/busy/done handshake
module gt_serial_ctrl
  import gt_serial_pkg::*;
#(
  parameter int W          = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         gt,
  output logic         eq,
  output logic         lt
);

  localparam int NS = W / SLICE_W;
  localparam int CW = $clog2(NS + 1);

  // Odd or sub-slice widths cannot be walked two bits at a time
  if (((W % 2) != 0) || (W < 2)) begin : g_bad_width
    $error("gt_serial_ctrl: W must be even and >= 2");
  end

  state_t         state;
  logic [W-1:0]   sa;
  logic [W-1:0]   sb;
  logic [CW-1:0]  cnt;
  logic           diff_seen;
  logic           dir;
  logic           s_gt;
  logic           s_eq;
  logic           dir_now;

  cmp2_slice u_slice (
    .x  (sa[W-1 -: SLICE_W]),
    .y  (sb[W-1 -: SLICE_W]),
    .gt (s_gt),
    .eq (s_eq)
  );

  // Direction of the first (most significant) differing slice, including the current one
  always_comb begin
    dir_now = diff_seen ? dir : s_gt;
  end

  // Handshake outputs follow the state directly
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // FSM, operand shift registers, slice counter and result registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      sa        <= '0;
      sb        <= '0;
      cnt       <= '0;
      diff_seen <= 1'b0;
      dir       <= 1'b0;
      gt        <= 1'b0;
      eq        <= 1'b0;
      lt        <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sa        <= a;
            sb        <= b;
            cnt       <= CW'(NS);
            diff_seen <= 1'b0;
            dir       <= 1'b0;
            gt        <= 1'b0;
            eq        <= 1'b0;
            lt        <= 1'b0;
            state     <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (!diff_seen && !s_eq) begin
            diff_seen <= 1'b1;
            dir       <= s_gt;
          end
          if (EARLY_EXIT && !s_eq) begin
            gt    <= s_gt;
            lt    <= ~s_gt;
            eq    <= 1'b0;
            state <= DONE;
          end else begin
            sa  <= sa << SLICE_W;
            sb  <= sb << SLICE_W;
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
              if (diff_seen || !s_eq) begin
                gt <= dir_now;
                lt <= ~dir_now;
                eq <= 1'b0;
              end else begin
                gt <= 1'b0;
                lt <= 1'b0;
                eq <= 1'b1;
              end
              state <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gt_serial_ctrl.sv
// tb/tb_gt_serial_ctrl.sv - randomized and directed bench for gt_serial_ctrl against a latency/result model
module tb_gt_serial_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] a8;
  logic [7:0] b8;

  logic [3:0] d_busy;
  logic [3:0] d_done;
  logic [3:0] d_gt;
  logic [3:0] d_eq;
  logic [3:0] d_lt;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  // index 0: W=8 early exit, 1: W=8 full scan, 2: W=4 early exit, 3: W=4 full scan
  gt_serial_ctrl #(.W(8), .EARLY_EXIT(1'b1)) u_w8_ee (
    .clk(clk), .reset_n(reset_n), .start(start), .a(a8), .b(b8),
    .busy(d_busy[0]), .done(d_done[0]), .gt(d_gt[0]), .eq(d_eq[0]), .lt(d_lt[0]));
  gt_serial_ctrl #(.W(8), .EARLY_EXIT(1'b0)) u_w8_fs (
    .clk(clk), .reset_n(reset_n), .start(start), .a(a8), .b(b8),
    .busy(d_busy[1]), .done(d_done[1]), .gt(d_gt[1]), .eq(d_eq[1]), .lt(d_lt[1]));
  gt_serial_ctrl #(.W(4), .EARLY_EXIT(1'b1)) u_w4_ee (
    .clk(clk), .reset_n(reset_n), .start(start), .a(a8[3:0]), .b(b8[3:0]),
    .busy(d_busy[2]), .done(d_done[2]), .gt(d_gt[2]), .eq(d_eq[2]), .lt(d_lt[2]));
  gt_serial_ctrl #(.W(4), .EARLY_EXIT(1'b0)) u_w4_fs (
    .clk(clk), .reset_n(reset_n), .start(start), .a(a8[3:0]), .b(b8[3:0]),
    .busy(d_busy[3]), .done(d_done[3]), .gt(d_gt[3]), .eq(d_eq[3]), .lt(d_lt[3]));

  function automatic int wd(input int i);
    return (i < 2) ? 8 : 4;
  endfunction

  function automatic bit ee(input int i);
    return (i % 2) == 0;
  endfunction

  // Cycles spent busy: first differing 2-bit slice from the MSB, or all slices
  function automatic int lat(input logic [7:0] x, input logic [7:0] y, input int w, input bit e);
    if (!e || (x == y)) return w / 2;
    for (int i = 1; i <= w / 2; i++) begin
      if (((x >> (w - 2 * i)) & 8'd3) != ((y >> (w - 2 * i)) & 8'd3)) return i;
    end
    return w / 2;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: per-DUT busy countdown and the arithmetic result of the accepted operands
  bit m_busy[4];
  bit m_done[4];
  bit m_gt[4];
  bit m_eq[4];
  bit m_lt[4];
  bit p_gt[4];
  bit p_eq[4];
  bit p_lt[4];
  int m_rem[4];

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      logic [7:0] x;
      logic [7:0] y;
      x = (wd(i) == 8) ? a8 : {4'h0, a8[3:0]};
      y = (wd(i) == 8) ? b8 : {4'h0, b8[3:0]};
      if (!reset_n) begin
        m_busy[i] <= 1'b0; m_done[i] <= 1'b0;
        m_gt[i] <= 1'b0; m_eq[i] <= 1'b0; m_lt[i] <= 1'b0;
        m_rem[i] <= 0;
      end else if (!m_busy[i] && start) begin
        m_busy[i] <= 1'b1; m_done[i] <= 1'b0;
        m_gt[i] <= 1'b0; m_eq[i] <= 1'b0; m_lt[i] <= 1'b0;
        m_rem[i] <= lat(x, y, wd(i), ee(i));
        p_gt[i] <= (x > y); p_eq[i] <= (x == y); p_lt[i] <= (x < y);
      end else if (m_busy[i]) begin
        if (m_rem[i] == 1) begin
          m_busy[i] <= 1'b0; m_done[i] <= 1'b1;
          m_gt[i] <= p_gt[i]; m_eq[i] <= p_eq[i]; m_lt[i] <= p_lt[i];
        end
        m_rem[i] <= m_rem[i] - 1;
      end else begin
        m_done[i] <= 1'b0;
      end
    end
  end

  // Every-cycle comparison of all four DUTs against the model
  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("dut%0d busy", i), int'(d_busy[i]), int'(m_busy[i]));
        chk($sformatf("dut%0d done", i), int'(d_done[i]), int'(m_done[i]));
        chk($sformatf("dut%0d gt", i), int'(d_gt[i]), int'(m_gt[i]));
        chk($sformatf("dut%0d eq", i), int'(d_eq[i]), int'(m_eq[i]));
        chk($sformatf("dut%0d lt", i), int'(d_lt[i]), int'(m_lt[i]));
        if (d_done[i])
          chk($sformatf("dut%0d onehot", i), $countones({d_gt[i], d_eq[i], d_lt[i]}), 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while ((m_busy[0] | m_busy[1] | m_busy[2] | m_busy[3]) && (n < bound)) begin
      tick();
      n++;
    end
    if (n >= bound) chk("wait_idle timeout", 1, 0);
  endtask

  // Start one compare and pin busy/done timing and result of one DUT with literal expectations
  task automatic run_pin(input logic [7:0] av, input logic [7:0] bv, input int idx,
                         input int k, input logic [2:0] res);
    wait_idle(20);
    a8 = av; b8 = bv; start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j < k; j++) begin
      chk($sformatf("pin%0d busy run", idx), int'(d_busy[idx]), 1);
      chk($sformatf("pin%0d done early", idx), int'(d_done[idx]), 0);
      tick();
    end
    chk($sformatf("pin%0d done", idx), int'(d_done[idx]), 1);
    chk($sformatf("pin%0d busy at done", idx), int'(d_busy[idx]), 0);
    chk($sformatf("pin%0d result", idx), int'({d_gt[idx], d_eq[idx], d_lt[idx]}), int'(res));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; a8 = 8'h00; b8 = 8'h00;
    tick();
    tick();
    chk("reset busy", int'(d_busy[0]), 0);
    chk("reset done", int'(d_done[0]), 0);
    chk("reset result", int'({d_gt[0], d_eq[0], d_lt[0]}), 0);
    chk_on = 1'b1;
    reset_n = 1'b1;
    tick();

    // MSB slice differs: one busy cycle, then gt
    run_pin(8'hC0, 8'h40, 0, 1, 3'b100);
    tick();
    chk("hold gt after done", int'(d_gt[0]), 1);
    chk("done single pulse", int'(d_done[0]), 0);
    // LSB slice differs, and equal operands: full latency
    run_pin(8'h5A, 8'h5B, 0, 4, 3'b001);
    run_pin(8'hA5, 8'hA5, 0, 4, 3'b010);
    // Full scan keeps the first-difference direction
    run_pin(8'hC0, 8'h40, 1, 4, 3'b100);

    // Start during RUN ignored; start held through DONE restarts immediately
    wait_idle(20);
    a8 = 8'h5A; b8 = 8'h5B; start = 1'b1;
    tick();
    a8 = 8'h00; b8 = 8'hFF;
    tick();
    tick();
    tick();
    a8 = 8'hC0; b8 = 8'h40;
    tick();
    chk("b2b first done", int'(d_done[0]), 1);
    chk("b2b first lt", int'(d_lt[0]), 1);
    tick();
    chk("b2b restart busy", int'(d_busy[0]), 1);
    chk("b2b restart done", int'(d_done[0]), 0);
    start = 1'b0;
    tick();
    chk("b2b second done", int'(d_done[0]), 1);
    chk("b2b second gt", int'(d_gt[0]), 1);

    // Reset mid-RUN discards the compare
    wait_idle(20);
    a8 = 8'h5A; b8 = 8'h5B; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("midreset busy", int'(d_busy[0]), 0);
    chk("midreset done", int'(d_done[0]), 0);
    chk("midreset result", int'({d_gt[0], d_eq[0], d_lt[0]}), 0);
    run_pin(8'hC0, 8'h40, 0, 1, 3'b100);

    // Randomized traffic with occasional resets and near-equal operands
    for (int c = 0; c < 1500; c++) begin
      a8 = 8'($urandom);
      if ($urandom_range(3) == 0)
        b8 = a8 ^ (8'($urandom_range(3)) << (2 * $urandom_range(3)));
      else
        b8 = 8'($urandom);
      start = ($urandom_range(2) == 0);
      reset_n = ($urandom_range(149) != 0);
      tick();
    end
    start = 1'b0;
    reset_n = 1'b1;
    tick();
    wait_idle(20);

    // Exhaustive W=4 operand pairs, upper bits random for the W=8 instances
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        a8 = {4'($urandom), 4'(x)};
        b8 = {4'($urandom), 4'(y)};
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(20);
        tick();
      end
    end

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
